// File: rtl/mmcm_drp_sequencer_if.sv
// Register-entry stream feeding the MMCM DRP sequencer.
// One beat = one read-modify-write of a DRP register.
interface mmcm_drp_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_mask;
  logic [15:0] cfg_data;
  logic        cfg_last;

  modport master (
    output cfg_valid, cfg_addr, cfg_mask,
    output cfg_data, cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_mask,
    input  cfg_data, cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/mmcm_drp_sequencer.sv
// MMCM reconfiguration: reset hold, DRP read-modify-write list, relock.
// Define MMCM_DRP_SEQUENCER_TIMEOUT_EN to bound DRDY and lock waits.
module mmcm_drp_sequencer #(
  parameter int RST_HOLD     = 8,
  parameter int LOCK_STABLE  = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                       dclk,
  input  logic                       rst,
  input  logic                       start,
  mmcm_drp_sequencer_if.slave        cfg,
  output logic [6:0]                 drp_addr,
  output logic [15:0]                drp_di,
  input  logic [15:0]                drp_do,
  output logic                       drp_den,
  output logic                       drp_dwe,
  input  logic                       drp_drdy,
  output logic                       mmcm_rst,
  input  logic                       mmcm_locked,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code
);

  typedef enum logic [3:0] {
    IDLE, HOLD, FETCH, RD, RD_WAIT,
    WR, WR_WAIT, RELEASE, WAIT_LOCK, DONE
  } state_t;

  localparam logic [15:0] HOLD_END = 16'(RST_HOLD - 1);
  localparam logic [15:0] LOCK_END = 16'(LOCK_STABLE - 1);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [15:0] lcnt;
  logic [15:0] mask_q;
  logic [15:0] data_q;
  logic        last_q;
  logic        blank_done;
  logic        to_drdy;
  logic        to_lock;

  // LOCKED is unreliable right after RST drops
  assign blank_done = (cnt >= 16'd2);

  always_comb begin
    state_n       = state;
    busy          = 1'b1;
    done          = 1'b0;
    cfg.cfg_ready = 1'b0;
    drp_den       = 1'b0;
    drp_dwe       = 1'b0;
    mmcm_rst      = 1'b1;
    unique case (state)
      IDLE: begin
        busy     = 1'b0;
        mmcm_rst = 1'b0;
        if (start) state_n = HOLD;
      end
      HOLD: if (cnt == HOLD_END) state_n = FETCH;
      FETCH: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) state_n = RD;
      end
      RD: begin
        drp_den = 1'b1;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (drp_drdy)     state_n = WR;
        else if (to_drdy) state_n = IDLE;
      end
      WR: begin
        drp_den = 1'b1;
        drp_dwe = 1'b1;
        state_n = WR_WAIT;
      end
      WR_WAIT: begin
        if (drp_drdy)     state_n = last_q ? RELEASE : FETCH;
        else if (to_drdy) state_n = IDLE;
      end
      RELEASE: begin
        mmcm_rst = 1'b0;
        state_n  = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        mmcm_rst = 1'b0;
        if (blank_done && mmcm_locked && lcnt == LOCK_END)
          state_n = DONE;
        else if (to_lock)
          state_n = IDLE;
      end
      DONE: begin
        mmcm_rst = 1'b0;
        done     = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lcnt     <= '0;
      drp_addr <= '0;
      drp_di   <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)    cnt <= '0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      if (state == WAIT_LOCK && blank_done)
        lcnt <= mmcm_locked ? lcnt + 16'd1 : '0;
      else
        lcnt <= '0;
      if (state == FETCH && cfg.cfg_valid) begin
        drp_addr <= cfg.cfg_addr;
        mask_q   <= cfg.cfg_mask;
        data_q   <= cfg.cfg_data;
        last_q   <= cfg.cfg_last;
      end
      // mask bit 1 keeps the MMCM's current bit
      if (state == RD_WAIT && drp_drdy)
        drp_di <= (drp_do & mask_q) | (data_q & ~mask_q);
    end
  end

`ifdef MMCM_DRP_SEQUENCER_TIMEOUT_EN
  localparam logic [15:0] DRDY_END = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_TEND = 16'(LOCK_TIMEOUT - 1);

  logic       err_q;
  logic [1:0] code_q;

  assign to_drdy  = (cnt == DRDY_END);
  assign to_lock  = (cnt == LOCK_TEND);
  assign error    = err_q;
  assign err_code = code_q;

  always_ff @(posedge dclk) begin
    if (rst) begin
      err_q  <= 1'b0;
      code_q <= 2'd0;
    end else begin
      err_q <= 1'b0;
      if (state == IDLE && start) begin
        code_q <= 2'd0;
      end else if (state_n == IDLE &&
                   (state == RD_WAIT || state == WR_WAIT)) begin
        err_q  <= 1'b1;
        code_q <= 2'd1;
      end else if (state_n == IDLE && state == WAIT_LOCK) begin
        err_q  <= 1'b1;
        code_q <= 2'd2;
      end
    end
  end
`else
  assign to_drdy  = 1'b0;
  assign to_lock  = 1'b0;
  assign error    = 1'b0;
  assign err_code = 2'd0;
`endif

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Scoreboard bench: random RMW lists against a DRP register-file model.
// Lock-time expectation is derived from the LOCKED waveform itself.
module tb_mmcm_drp_sequencer;
  localparam int RST_HOLD     = 8;
  localparam int LOCK_STABLE  = 4;
  localparam int DRDY_TIMEOUT = 64;
  localparam int LOCK_TIMEOUT = 65535;

  logic        dclk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0;
  logic        drp_den;
  logic        drp_dwe;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  mmcm_drp_sequencer_if cfg();

  mmcm_drp_sequencer #(
    .RST_HOLD(RST_HOLD),
    .LOCK_STABLE(LOCK_STABLE),
    .DRDY_TIMEOUT(DRDY_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .dclk(dclk),
    .rst(rst),
    .start(start),
    .cfg(cfg.slave),
    .drp_addr(drp_addr),
    .drp_di(drp_di),
    .drp_do(drp_do),
    .drp_den(drp_den),
    .drp_dwe(drp_dwe),
    .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst),
    .mmcm_locked(mmcm_locked),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        mon_e;
  logic [15:0] mem [128];
  logic [15:0] exp_mem [128];
  logic [6:0]  ent_a[$];
  logic [15:0] ent_m[$];
  logic [15:0] ent_d[$];

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int fixed_lat = 0;
  bit hang = 0;
  bit stray_req = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // monitor: every DRP strobe must match the next scoreboard entry
  always @(negedge dclk) begin
    if (done) done_seen++;
    if (drp_den) begin
      chk("mmcm_rst_during_drp", 32'(mmcm_rst), 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_drp actual=we%0d/addr%0h expected=none",
                 drp_dwe, drp_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drp_dwe", 32'(drp_dwe), 32'(mon_e.wr));
        chk("drp_addr", 32'(drp_addr), 32'(mon_e.addr));
        if (mon_e.wr) chk("drp_di", 32'(drp_di), 32'(mon_e.data));
      end
    end
  end

  // DRP register-file model with random acknowledge latency
  int          cd = 0;
  bit          pend = 0;
  bit          pwr = 0;
  logic [6:0]  paddr = 7'h0;
  always @(negedge dclk) begin
    drp_drdy = 1'b0;
    if (pend) begin
      cd--;
      if (cd == 0) begin
        drp_drdy = 1'b1;
        drp_do   = pwr ? 16'($urandom) : mem[paddr];
        pend     = 0;
      end
    end
    if (drp_den && !hang) begin
      pend  = 1;
      paddr = drp_addr;
      pwr   = drp_dwe;
      cd    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      if (drp_dwe) mem[drp_addr] = drp_di;
    end
    if (stray_req) begin
      drp_drdy  = 1'b1;
      drp_do    = 16'($urandom);
      stray_req = 0;
    end
  end

  task automatic add_ent(input logic [6:0] a, input logic [15:0] m,
                         input logic [15:0] d);
    ent_a.push_back(a);
    ent_m.push_back(m);
    ent_d.push_back(d);
  endtask

  task automatic run_txn(input int gap, input logic [31:0] lpat,
                         input bit inject);
    int n, k, r, got, exp_r, run, d0;
    logic [15:0] old, nv;
    n = ent_a.size();
    for (int i = 0; i < n; i++) begin
      old = exp_mem[ent_a[i]];
      nv  = (old & ent_m[i]) | (ent_d[i] & ~ent_m[i]);
      exp_q.push_back('{1'b0, ent_a[i], old});
      exp_q.push_back('{1'b1, ent_a[i], nv});
      exp_mem[ent_a[i]] = nv;
    end
    exp_r = -1;
    run = 0;
    for (int j = 3; j < 40; j++) begin
      if (exp_r < 0) begin
        run = (j >= 32 || lpat[j]) ? run + 1 : 0;
        if (run == LOCK_STABLE) exp_r = j + 1;
      end
    end
    d0 = done_seen;
    mmcm_locked = 1'b0;
    start = 1'b1;
    @(negedge dclk);
    start = 1'b0;
    k = 1;
    while (!cfg.cfg_ready && k < 100) begin
      @(negedge dclk);
      k++;
    end
    chk("hold_cycles", 32'(k), 32'(RST_HOLD + 1));
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!cfg.cfg_ready && k < 300) begin
        @(negedge dclk);
        k++;
      end
      chk("fetch_reached", 32'(cfg.cfg_ready), 32'd1);
      for (int g = 0; g < gap; g++) begin
        if (inject && g == 1) begin
          start = 1'b1;
          stray_req = 1;
        end else begin
          start = 1'b0;
        end
        @(negedge dclk);
      end
      start = 1'b0;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_addr  = ent_a[i];
      cfg.cfg_mask  = ent_m[i];
      cfg.cfg_data  = ent_d[i];
      cfg.cfg_last  = (i == n - 1);
      @(negedge dclk);
      cfg.cfg_valid = 1'b0;
    end
    k = 0;
    while (!(busy && !mmcm_rst) && k < 500) begin
      @(negedge dclk);
      k++;
    end
    chk("release_reached", 32'(busy && !mmcm_rst), 32'd1);
    r = 0;
    got = -1;
    while (r < 40) begin
      if (done) begin
        got = r;
        break;
      end
      mmcm_locked = (r >= 32) ? 1'b1 : lpat[r];
      @(negedge dclk);
      r++;
    end
    chk("done_cycle", 32'(got), 32'(exp_r));
    @(negedge dclk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_seen - d0), 32'd1);
    chk("drp_all_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    ent_a.delete();
    ent_m.delete();
    ent_d.delete();
  endtask

  task automatic start_one(input logic [6:0] a);
    int k;
    start = 1'b1;
    @(negedge dclk);
    start = 1'b0;
    k = 0;
    while (!cfg.cfg_ready && k < 100) begin
      @(negedge dclk);
      k++;
    end
    cfg.cfg_valid = 1'b1;
    cfg.cfg_addr  = a;
    cfg.cfg_mask  = 16'h00FF;
    cfg.cfg_data  = 16'h1234;
    cfg.cfg_last  = 1'b1;
    @(negedge dclk);
    cfg.cfg_valid = 1'b0;
    k = 0;
    while (!drp_den && k < 20) begin
      @(negedge dclk);
      k++;
    end
    chk("rd_strobe", 32'(drp_den), 32'd1);
  endtask

  task automatic run_reset_abort();
    int d0;
    logic [6:0] a;
    a = 7'h2A;
    d0 = done_seen;
    exp_q.push_back('{1'b0, a, exp_mem[a]});
    fixed_lat = 4;
    mmcm_locked = 1'b0;
    start_one(a);
    @(negedge dclk);
    rst = 1'b1;
    @(negedge dclk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mmcm_rst", 32'(mmcm_rst), 32'd0);
    chk("abort_den", 32'(drp_den), 32'd0);
    chk("abort_addr", 32'(drp_addr), 32'd0);
    repeat (6) @(negedge dclk);
    chk("abort_busy_late", 32'(busy), 32'd0);
    chk("abort_di", 32'(drp_di), 32'd0);
    chk("abort_ready", 32'(cfg.cfg_ready), 32'd0);
    chk("abort_no_write", 32'(mem[a]), 32'(exp_mem[a]));
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    fixed_lat = 0;
  endtask

`ifdef MMCM_DRP_SEQUENCER_TIMEOUT_EN
  task automatic run_drdy_timeout();
    int k;
    logic [6:0] a;
    a = 7'h33;
    exp_q.push_back('{1'b0, a, exp_mem[a]});
    hang = 1;
    start_one(a);
    k = 0;
    while (!error && k < 200) begin
      @(negedge dclk);
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'(DRDY_TIMEOUT + 1));
    chk("timeout_code", 32'(err_code), 32'd1);
    chk("timeout_mmcm_rst", 32'(mmcm_rst), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    @(negedge dclk);
    chk("timeout_pulse", 32'(error), 32'd0);
    chk("timeout_code_held", 32'(err_code), 32'd1);
    hang = 0;
    exp_q.delete();
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 16'($urandom);
      exp_mem[i] = mem[i];
    end
    rst = 1'b1;
    start = 1'b0;
    mmcm_locked = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_addr = 7'h0;
    cfg.cfg_mask = 16'h0;
    cfg.cfg_data = 16'h0;
    cfg.cfg_last = 1'b0;
    repeat (3) @(negedge dclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_ready", 32'(cfg.cfg_ready), 32'd0);
    chk("rst_den", 32'(drp_den), 32'd0);
    chk("rst_dwe", 32'(drp_dwe), 32'd0);
    chk("rst_addr", 32'(drp_addr), 32'd0);
    chk("rst_di", 32'(drp_di), 32'd0);
    chk("rst_mmcm_rst", 32'(mmcm_rst), 32'd0);
    rst = 1'b0;
    @(negedge dclk);

    mem[8] = 16'hABCD;
    exp_mem[8] = 16'hABCD;
    add_ent(7'h08, 16'hF000, 16'h0145);
    run_txn(0, 32'hFFFF_FFFF, 0);
    chk("single_rmw_value", 32'(mem[8]), 32'hA145);

    add_ent(7'h10, 16'h0F0F, 16'h5A5A);
    add_ent(7'h11, 16'hFFFF, 16'h0000);
    add_ent(7'h12, 16'h0000, 16'hC3C3);
    run_txn(5, 32'hFFFF_FFFF, 1);
    chk("full_replace", 32'(mem[7'h12]), 32'hC3C3);

    add_ent(7'h20, 16'h00FF, 16'hBEEF);
    run_txn(1, 32'hFFFF_FFEF, 0);

    run_reset_abort();

    for (int t = 0; t < 8; t++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++)
        add_ent(7'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      run_txn(int'($urandom_range(0, 3)),
              {16'hFFFF, 16'($urandom)}, 0);
    end

`ifdef MMCM_DRP_SEQUENCER_TIMEOUT_EN
    run_drdy_timeout();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
